inference_scheduler: RTL and testbench
======================================

// Module: inference_scheduler
// PURPOSE
//  Front-end sequencer for the MNIST accelerator core. It accepts a host pixel stream
//  (valid/ready), frames it into IMG_PIXELS-pixel images and drives the core's
//  i_valid/pixel inputs, keeping at most one image in flight.
//  It captures the core's class scores, runs a sequential argmax over them, and returns
//  {digit, score} on a valid/ready result port.
// PARAMETERS
//  DATA_WIDTH     16    pixel / score width; scores are two's-complement signed
//  IMG_PIXELS     784   pixels per image
//  NUM_CLASSES    10    number of core output scores (<=16)
//  TIMEOUT_CYCLES 4096  WAIT-state watchdog limit (used only with SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1                     system clock
//  rst          in   1                     reset; asynchronous, active-low
//  s_valid      in   1                     host pixel valid
//  s_ready      out  1                     scheduler can accept a pixel
//  s_pixel      in   DATA_WIDTH            host pixel
//  core_rst     out  1                     core reset (active-high, synchronous at the core)
//  core_valid   out  1                     drives core i_valid
//  core_pixel   out  DATA_WIDTH            drives core pixel
//  core_o_valid in   1                     core result valid
//  core_scores  in   NUM_CLASSES*DATA_WIDTH  packed scores; class k at [k*DW +: DW]
//  m_valid      out  1                     result valid
//  m_ready      in   1                     result accepted
//  m_digit      out  4                     argmax class index
//  m_score      out  DATA_WIDTH            winning score
//  busy         out  1                     state != IDLE
//  img_count    out  16                    number of results delivered
//  err          out  1                     sticky watchdog error
// BEHAVIOUR
//  Clocking and reset:
//  - One clock; reset is asynchronous and active-low.
//  - Reset values: s_ready=0, core_valid=0, core_pixel=0, m_valid=0, m_digit=0, m_score=0,
//    busy=1, img_count=0, err=0, core_rst=1.
//  - Reset mid-operation discards any partial image or result and clears all counters.
//  States: INIT -> IDLE -> STREAM -> WAIT -> ARGMAX -> (HOLD) -> IDLE.
//  - INIT: core_rst=1 for 2 cycles after rst deasserts, then IDLE.
//  - IDLE/STREAM: s_ready=1. Each handshake appears on core_valid/core_pixel exactly 1 cycle
//    later (registered). A cycle with no handshake gives core_valid=0 (bubbles allowed).
//    pix_cnt increments per handshake. The IMG_PIXELS-th handshake moves to WAIT and
//    resets pix_cnt to 0.
//  - WAIT: s_ready=0. On core_o_valid, latch all core_scores and go to ARGMAX.
//  - core_o_valid in any other state is ignored.
//  - ARGMAX: one comparison per cycle, indices 1..NUM_CLASSES-1, so NUM_CLASSES-1 cycles.
//    - Signed compare, strict '>', so ties keep the lowest index.
//    - On finish: if m_valid=0 or m_ready=1, load m_digit/m_score, set m_valid=1,
//      increment img_count, go to IDLE. Otherwise go to HOLD.
//  - HOLD: wait until m_valid=0 or m_ready=1, then load the result as above and go to IDLE.
//  - Result handshake: m_valid, m_digit and m_score stay stable until m_valid&&m_ready.
//    m_valid drops the next cycle unless a new result loads in that same cycle.
//  - A pending, unaccepted result does not block streaming of the next image.
//  - img_count wraps 0xFFFF -> 0.
//  - Latency: last pixel handshake -> core_valid +1 cycle.
//    core_o_valid -> m_valid = NUM_CLASSES cycles (no backpressure).
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined:
//  - A watchdog counts cycles in WAIT. When it reaches TIMEOUT_CYCLES: err<=1 (sticky until
//    rst), core_rst pulses for 2 cycles, state -> IDLE, no result emitted, img_count unchanged.
//  SCHED_TIMEOUT_EN undefined:
//  - WAIT waits indefinitely, err is tied 0, and TIMEOUT_CYCLES is unused.
// TESTING
//  1 Reset then release: core_rst=1 for 2 cycles after release, then s_ready=1,
//    busy=0, all other outputs 0.
//  2 784 back-to-back pixels, then core_o_valid with scores {3,-5,9,9,0,...}:
//    m_digit=2, m_score=9, m_valid=1 ten cycles later, img_count=1.
//  3 Random s_valid gaps: core_valid count equals 784 exactly; s_ready=0 from the cycle
//    after the 784th handshake until core_o_valid.
//  4 m_ready=0 for 50 cycles while a second image completes: first result is held
//    unchanged, second enters HOLD and is delivered right after the first handshake;
//    img_count=2.
//  5 rst asserted after 400 pixels: outputs return to reset values immediately; a full
//    new image then gives a correct result with img_count=1.
//  6 SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, no core_o_valid: after 100 WAIT cycles err=1,
//    core_rst pulses 2 cycles, m_valid stays 0, s_ready=1.

Source files
------------

// File: rtl/inference_scheduler.sv
// inference_scheduler: frames a host pixel stream into images for the MNIST core, captures
// its class scores and returns {digit, score}. Optional WAIT watchdog: define SCHED_TIMEOUT_EN.
module inference_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int IMG_PIXELS     = 784,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_pixel,
  output logic                              core_rst,
  output logic                              core_valid,
  output logic [DATA_WIDTH-1:0]             core_pixel,
  input  logic                              core_o_valid,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] core_scores,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [3:0]                        m_digit,
  output logic [DATA_WIDTH-1:0]             m_score,
  output logic                              busy,
  output logic [15:0]                       img_count,
  output logic                              err
);
  localparam int PIX_W = $clog2(IMG_PIXELS + 1);
  localparam int SC_W  = NUM_CLASSES * DATA_WIDTH;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_PIXELS - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_CLASSES - 1);

  if (NUM_CLASSES < 2 || NUM_CLASSES > 16 || IMG_PIXELS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("inference_scheduler: unsupported parameter values");
  end

  typedef enum logic [2:0] {INIT, IDLE, STREAM, WAIT, ARGMAX, HOLD} state_t;
  state_t state, state_n;

  logic [1:0]                   rst_cnt;
  logic [PIX_W-1:0]             pix_cnt;
  logic [SC_W-1:0]              score_sh;
  logic [3:0]                   arg_idx, best_idx, fin_idx, res_digit;
  logic signed [DATA_WIDTH-1:0] best_score, cand_score, fin_score;
  logic [DATA_WIDTH-1:0]        res_score;
  logic                         hs, pix_last, arg_last, res_free;
  logic                         capture, load_res, timeout, wd_expire;

  assign s_ready  = (state == IDLE) || (state == STREAM);
  assign busy     = (state != IDLE);
  assign hs       = s_valid && s_ready;
  assign pix_last = hs && (pix_cnt == PIX_LAST);
  assign arg_last = (arg_idx == IDX_LAST);
  assign res_free = !m_valid || m_ready;
  assign core_rst = (rst_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    load_res = 1'b0;
    timeout  = 1'b0;
    case (state)
      INIT: if (rst_cnt == 2'd1) state_n = IDLE;
      IDLE, STREAM: if (hs) state_n = pix_last ? WAIT : STREAM;
      WAIT: begin
        if (core_o_valid) begin
          capture = 1'b1;
          state_n = ARGMAX;
        end else if (wd_expire) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      ARGMAX: begin
        if (arg_last) begin
          load_res = res_free;
          state_n  = res_free ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (res_free) begin
          load_res = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = INIT;
    endcase
  end

  // core_rst is held for two cycles after reset release and again after a watchdog abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  rst_cnt <= 2'd2;
    else if (timeout)          rst_cnt <= 2'd2;
    else if (rst_cnt != 2'd0)  rst_cnt <= rst_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_valid <= 1'b0;
      core_pixel <= '0;
      pix_cnt    <= '0;
    end else begin
      core_valid <= hs;
      if (hs) begin
        core_pixel <= s_pixel;
        pix_cnt    <= pix_last ? '0 : pix_cnt + PIX_W'(1);
      end
    end
  end

  // Scores are shifted down one class per cycle so the candidate is always the second slot
  assign cand_score = score_sh[DATA_WIDTH +: DATA_WIDTH];
  assign fin_idx    = (cand_score > best_score) ? arg_idx    : best_idx;
  assign fin_score  = (cand_score > best_score) ? cand_score : best_score;
  assign res_digit  = (state == ARGMAX) ? fin_idx : best_idx;
  assign res_score  = (state == ARGMAX) ? fin_score : best_score;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_sh   <= '0;
      best_score <= '0;
      best_idx   <= '0;
      arg_idx    <= '0;
    end else if (capture) begin
      score_sh   <= core_scores;
      best_score <= core_scores[DATA_WIDTH-1:0];
      best_idx   <= 4'd0;
      arg_idx    <= 4'd1;
    end else if (state == ARGMAX) begin
      score_sh   <= score_sh >> DATA_WIDTH;
      best_score <= fin_score;
      best_idx   <= fin_idx;
      arg_idx    <= arg_idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid   <= 1'b0;
      m_digit   <= '0;
      m_score   <= '0;
      img_count <= '0;
    end else if (load_res) begin
      m_valid   <= 1'b1;
      m_digit   <= res_digit;
      m_score   <= res_score;
      img_count <= img_count + 16'd1;
    end else if (m_valid && m_ready) begin
      m_valid   <= 1'b0;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT && state_n == WAIT) ? wd_cnt + WD_W'(1) : '0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_inference_scheduler.sv
// tb_inference_scheduler: directed checks of framing, argmax, result backpressure,
// mid-image reset and (with SCHED_TIMEOUT_EN) the WAIT watchdog.
`timescale 1ns/1ps
module tb_inference_scheduler;
  localparam int DW = 16;
  localparam int NP = 784;
  localparam int NC = 10;
  localparam int TO = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_pixel;
  logic             core_rst;
  logic             core_valid;
  logic [DW-1:0]    core_pixel;
  logic             core_o_valid;
  logic [NC*DW-1:0] core_scores;
  logic             m_valid;
  logic             m_ready;
  logic [3:0]       m_digit;
  logic [DW-1:0]    m_score;
  logic             busy;
  logic [15:0]      img_count;
  logic             err;

  int checks = 0;
  int errors = 0;

  inference_scheduler #(
    .DATA_WIDTH(DW), .IMG_PIXELS(NP), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .core_rst(core_rst), .core_valid(core_valid), .core_pixel(core_pixel),
    .core_o_valid(core_o_valid), .core_scores(core_scores),
    .m_valid(m_valid), .m_ready(m_ready), .m_digit(m_digit), .m_score(m_score),
    .busy(busy), .img_count(img_count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] pack(input int s0, input int s1, input int s2, input int s3,
                                            input int s4, input int s5, input int s6, input int s7,
                                            input int s8, input int s9);
    int s [NC];
    logic [NC*DW-1:0] v;
    s = '{s0, s1, s2, s3, s4, s5, s6, s7, s8, s9};
    v = '0;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = DW'(s[k]);
    return v;
  endfunction

  // Streams n pixels; each handshake must show up on core_valid/core_pixel one cycle later
  task automatic apply_stimulus(input int n, input bit gaps, input logic [DW-1:0] key);
    int seen = 0;
    int bad  = 0;
    int g;
    logic [DW-1:0] pix;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          s_valid = 1'b0;
          tick();
          if (core_valid !== 1'b0) bad++;
        end
      end
      pix = DW'(i * 7) ^ key;
      s_valid = 1'b1;
      s_pixel = pix;
      tick();
      if (core_valid === 1'b1) seen++;
      if (core_valid !== 1'b1 || core_pixel !== pix) bad++;
    end
    s_valid = 1'b0;
    s_pixel = '0;
    check_output("core_valid_count", seen, n);
    check_output("pixel_path", bad, 0);
  endtask

  task automatic give_scores(input logic [NC*DW-1:0] v);
    core_o_valid = 1'b1;
    core_scores  = v;
    tick();
    core_o_valid = 1'b0;
    core_scores  = '0;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_pixel = '0;
    core_o_valid = 1'b0; core_scores = '0; m_ready = 1'b0;
    repeat (3) tick();

    $display("[TB] reset state and release");
    check_output("rst_s_ready", s_ready, 0);
    check_output("rst_core_valid", core_valid, 0);
    check_output("rst_core_pixel", core_pixel, 0);
    check_output("rst_m_valid", m_valid, 0);
    check_output("rst_m_digit", m_digit, 0);
    check_output("rst_m_score", m_score, 0);
    check_output("rst_busy", busy, 1);
    check_output("rst_img_count", img_count, 0);
    check_output("rst_err", err, 0);
    check_output("rst_core_rst", core_rst, 1);
    rst = 1'b1;
    tick();
    check_output("init1_core_rst", core_rst, 1);
    check_output("init1_s_ready", s_ready, 0);
    tick();
    check_output("init2_core_rst", core_rst, 0);
    check_output("idle_s_ready", s_ready, 1);
    check_output("idle_busy", busy, 0);

    $display("[TB] image A back-to-back, tie resolves to lower index");
    apply_stimulus(NP, 1'b0, 16'h0000);
    check_output("a_wait_s_ready", s_ready, 0);
    check_output("a_wait_busy", busy, 1);
    repeat (3) tick();
    give_scores(pack(3, -5, 9, 9, 0, 0, 0, 0, 0, 0));
    repeat (8) tick();
    check_output("a_m_valid_early", m_valid, 0);
    tick();
    check_output("a_m_valid", m_valid, 1);
    check_output("a_m_digit", m_digit, 2);
    check_output("a_m_score", m_score, 9);
    check_output("a_img_count", img_count, 1);
    check_output("a_busy", busy, 0);
    m_ready = 1'b1;
    tick();
    check_output("a_m_valid_drop", m_valid, 0);

    $display("[TB] core_o_valid outside WAIT is ignored");
    give_scores(pack(1, 2, 3, 4, 5, 6, 7, 8, 9, 10));
    repeat (12) tick();
    check_output("ign_m_valid", m_valid, 0);
    check_output("ign_busy", busy, 0);
    check_output("ign_img_count", img_count, 1);

    $display("[TB] image B with gaps, negative scores");
    apply_stimulus(NP, 1'b1, 16'hA5A5);
    check_output("b_wait_s_ready", s_ready, 0);
    repeat (5) tick();
    check_output("b_wait_s_ready_late", s_ready, 0);
    give_scores(pack(-100, -100, -100, -100, -3, -100, -100, -200, -100, -3));
    repeat (8) tick();
    check_output("b_m_valid_early", m_valid, 0);
    tick();
    check_output("b_m_valid", m_valid, 1);
    check_output("b_m_digit", m_digit, 4);
    check_output("b_m_score", m_score, 16'hFFFD);
    check_output("b_img_count", img_count, 2);
    tick();
    check_output("b_m_valid_drop", m_valid, 0);

    $display("[TB] backpressure: second image lands in HOLD");
    m_ready = 1'b0;
    apply_stimulus(NP, 1'b0, 16'h0F0F);
    give_scores(pack(32767, 100, -1, 32766, 0, 5, 5, 5, 5, 5));
    repeat (9) tick();
    check_output("c_m_valid", m_valid, 1);
    check_output("c_m_digit", m_digit, 0);
    check_output("c_m_score", m_score, 16'h7FFF);
    check_output("c_img_count", img_count, 3);
    apply_stimulus(NP, 1'b0, 16'h1234);
    check_output("c_held_digit", m_digit, 0);
    give_scores(pack(-1, -1, -1, -1, -1, -1, -1, -1, 499, 500));
    repeat (12) tick();
    check_output("hold_busy", busy, 1);
    check_output("hold_m_valid", m_valid, 1);
    check_output("hold_m_digit", m_digit, 0);
    check_output("hold_m_score", m_score, 16'h7FFF);
    check_output("hold_img_count", img_count, 3);
    m_ready = 1'b1;
    tick();
    check_output("d_m_valid", m_valid, 1);
    check_output("d_m_digit", m_digit, 9);
    check_output("d_m_score", m_score, 16'h01F4);
    check_output("d_img_count", img_count, 4);
    check_output("d_busy", busy, 0);
    tick();
    check_output("d_m_valid_drop", m_valid, 0);

    $display("[TB] reset in the middle of an image");
    apply_stimulus(400, 1'b0, 16'h5555);
    rst = 1'b0;
    #1;
    check_output("mid_core_rst", core_rst, 1);
    check_output("mid_s_ready", s_ready, 0);
    check_output("mid_busy", busy, 1);
    check_output("mid_core_valid", core_valid, 0);
    check_output("mid_core_pixel", core_pixel, 0);
    check_output("mid_img_count", img_count, 0);
    check_output("mid_m_digit", m_digit, 0);
    check_output("mid_m_score", m_score, 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check_output("mid_idle_s_ready", s_ready, 1);
    apply_stimulus(NP, 1'b0, 16'h3C3C);
    give_scores(pack(3, -5, 9, 9, 0, 0, 0, 0, 0, 0));
    repeat (9) tick();
    check_output("e_m_valid", m_valid, 1);
    check_output("e_m_digit", m_digit, 2);
    check_output("e_m_score", m_score, 9);
    check_output("e_img_count", img_count, 1);

`ifdef SCHED_TIMEOUT_EN
    $display("[TB] watchdog abort in WAIT");
    apply_stimulus(NP, 1'b0, 16'h00FF);
    repeat (99) tick();
    check_output("wd_before_err", err, 0);
    check_output("wd_before_s_ready", s_ready, 0);
    tick();
    check_output("wd_err", err, 1);
    check_output("wd_core_rst1", core_rst, 1);
    check_output("wd_s_ready", s_ready, 1);
    check_output("wd_m_valid", m_valid, 0);
    check_output("wd_busy", busy, 0);
    tick();
    check_output("wd_core_rst2", core_rst, 1);
    tick();
    check_output("wd_core_rst_end", core_rst, 0);
    check_output("wd_err_sticky", err, 1);
    check_output("wd_img_count", img_count, 1);
`else
    $display("[TB] WAIT without watchdog");
    apply_stimulus(NP, 1'b0, 16'h00FF);
    repeat (150) tick();
    check_output("nowd_err", err, 0);
    check_output("nowd_s_ready", s_ready, 0);
    check_output("nowd_busy", busy, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
